// File: rtl/msgram_arbiter.sv
// Single-port CAN message RAM arbiter. It grants fixed-length read or write bursts
// with round-robin on ties, drives the RAM strobes and owns the bidirectional data bus.
module msgram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int MSGLEN     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_done,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_base,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic                  wr_done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    localparam int CW = (MSGLEN > 1) ? $clog2(MSGLEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(MSGLEN - 1);

    typedef enum logic [2:0] {IDLE, RD, DRAIN, WR, TURN} state_t;

    state_t                state, state_nx;
    logic                  last_wr, last_wr_nx;
    logic [ADDR_WIDTH-1:0] base, base_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  cnt_end;
    logic                  cap, cap_last;

    assign cnt_end = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_wr <= 1'b1;
            base    <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            last_wr <= last_wr_nx;
            base    <= base_nx;
            cnt     <= cnt_nx;
        end
    end

    // Requests are looked at only in IDLE; a tie goes to the side not served last.
    always_comb begin
        state_nx   = state;
        last_wr_nx = last_wr;
        base_nx    = base;
        cnt_nx     = cnt;
        case (state)
            IDLE: begin
                if (rd_req && (!wr_req || last_wr)) begin
                    state_nx   = RD;
                    last_wr_nx = 1'b0;
                    base_nx    = rd_base;
                    cnt_nx     = '0;
                end else if (wr_req) begin
                    state_nx   = WR;
                    last_wr_nx = 1'b1;
                    base_nx    = wr_base;
                    cnt_nx     = '0;
                end
            end
            RD: begin
                cnt_nx = cnt + 1'b1;
                if (cnt_end) begin
                    state_nx = DRAIN;
                    cnt_nx   = '0;
                end
            end
            DRAIN: state_nx = TURN;
            WR: begin
                cnt_nx = cnt + 1'b1;
                if (cnt_end) begin
                    state_nx = TURN;
                    cnt_nx   = '0;
                end
            end
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshakes: wr_ack is the ready for wr_data -- the byte presented while wr_ack is
    // high is consumed at that clock edge. rd_valid has no backpressure; rd_data is
    // meaningful only in a cycle with rd_valid high.
    assign busy     = (state != IDLE);
    assign ram_cs   = (state == RD) || (state == WR);
    assign ram_we   = (state == WR);
    assign ram_oe   = (state == RD) || (state == DRAIN);
    assign ram_addr = ram_cs ? (base + ADDR_WIDTH'(cnt)) : '0;
    assign ram_data = (state == WR) ? wr_data : 'z;
    assign wr_ack   = (state == WR);
    assign wr_done  = (state == WR) && cnt_end;

    // The RAM answers one cycle after the address; DRAIN keeps oe up for the last byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap      <= 1'b0;
            cap_last <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
        end else begin
            cap      <= (state == RD);
            cap_last <= (state == RD) && cnt_end;
            rd_valid <= cap;
            rd_done  <= cap_last;
            if (cap) begin
                rd_data <= ram_data;
            end
        end
    end

endmodule

// File: tb/tb_msgram_arbiter.sv
// Bench for msgram_arbiter: directed bursts with a synchronous RAM model; expected
// bytes, addresses and cycles go into queues that a negedge monitor drains.
module tb_msgram_arbiter;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int ML = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_base, wr_base;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_done, wr_ack, wr_done, busy;
    logic [AW-1:0] ram_addr;
    logic          ram_cs, ram_we, ram_oe;
    wire  [DW-1:0] ram_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] wbuf    [ML];

    logic [DW-1:0] rd_exp_q[$];
    int            rd_cyc_q[$];
    logic          rd_last_q[$];
    logic [DW-1:0] wr_exp_q[$];
    logic [AW-1:0] wr_addr_q[$];
    int            wr_cyc_q[$];
    logic          wr_last_q[$];
    logic          g_kind_q[$];
    int            g_cyc_q[$];
    logic          cs_prev = 1'b0;

    msgram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MSGLEN(ML)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_base(rd_base), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_done(rd_done),
        .wr_req(wr_req), .wr_base(wr_base), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_done(wr_done), .busy(busy),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_data(ram_data)
    );

    // clock / cycle counter / RAM model
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ram_data = ram_oe ? ram_q : 'z;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        if (ram_cs && !ram_we) ram_q <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bus_busy();
        return ((|ram_data) === 1'b1);
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        check("oe_we_excl", 32'(ram_oe & ram_we), 32'd0);
        if (!ram_oe && !ram_we) check("bus_released", 32'(bus_busy()), 32'd0);
        if (rd_valid) begin
            if (rd_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 data %0h, expected no read", rd_data);
            end else begin
                check("rd_data", 32'(rd_data), 32'(rd_exp_q.pop_front()));
                check("rd_done", 32'(rd_done), 32'(rd_last_q.pop_front()));
                check("rd_cycle", cyc, rd_cyc_q.pop_front());
            end
        end else begin
            check("rd_done_stray", 32'(rd_done), 32'd0);
        end
        if (wr_ack) begin
            if (wr_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_ack_unexpected: got wr_ack=1 at addr %0h, expected no write", ram_addr);
            end else begin
                check("wr_addr", 32'(ram_addr), 32'(wr_addr_q.pop_front()));
                check("wr_bus", 32'(ram_data), 32'(wr_exp_q.pop_front()));
                check("wr_done", 32'(wr_done), 32'(wr_last_q.pop_front()));
                check("wr_cycle", cyc, wr_cyc_q.pop_front());
            end
        end else begin
            check("wr_done_stray", 32'(wr_done), 32'd0);
        end
        if (ram_cs && !cs_prev) begin
            if (g_cyc_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL grant_unexpected: got burst start we=%0b, expected none", ram_we);
            end else begin
                check("grant_kind", 32'(ram_we), 32'(g_kind_q.pop_front()));
                check("grant_cycle", cyc, g_cyc_q.pop_front());
            end
        end
        cs_prev = ram_cs;
    end

    // driver tasks
    task automatic wait_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy stuck at 1, expected 0");
        end
    endtask

    task automatic push_read(input logic [AW-1:0] base, input int t);
        logic [AW-1:0] a;
        g_kind_q.push_back(1'b0);
        g_cyc_q.push_back(t + 1);
        for (int i = 0; i < ML; i++) begin
            a = base + AW'(i);
            rd_exp_q.push_back(ref_mem[a]);
            rd_cyc_q.push_back(t + 3 + i);
            rd_last_q.push_back(i == ML - 1);
        end
    endtask

    task automatic push_write(input logic [AW-1:0] base, input int t, input int n);
        logic [AW-1:0] a;
        g_kind_q.push_back(1'b1);
        g_cyc_q.push_back(t + 1);
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            wr_addr_q.push_back(a);
            wr_exp_q.push_back(wbuf[i]);
            wr_cyc_q.push_back(t + 1 + i);
            wr_last_q.push_back(i == ML - 1);
            ref_mem[a] = wbuf[i];
        end
    endtask

    task automatic run_read(input logic [AW-1:0] base);
        int t;
        wait_idle();
        t = cyc;
        rd_base = base;
        rd_req  = 1'b1;
        push_read(base, t);
        @(negedge clk);
        rd_req = 1'b0;
        wait_cycle(t + ML + 2);
        check("rd_turn_busy", 32'(busy), 32'd1);
        check("rd_turn_oe", 32'(ram_oe), 32'd0);
        wait_cycle(t + ML + 3);
        check("rd_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_write(input logic [AW-1:0] base, input logic chain, input logic [AW-1:0] cbase);
        int t, k, g;
        wait_idle();
        t = cyc;
        wr_base = base;
        wr_data = wbuf[0];
        wr_req  = 1'b1;
        push_write(base, t, ML);
        k = 0;
        g = 0;
        while (k < ML && g < 4 * ML) begin
            @(negedge clk);
            g++;
            if (cyc == t + 1) begin
                wr_req = 1'b0;
                if (chain) begin
                    rd_base = cbase;
                    rd_req  = 1'b1;
                end
            end
            if (wr_ack) begin
                @(posedge clk);
                #1;
                k++;
                if (k < ML) wr_data = wbuf[k];
            end
        end
        if (k < ML) begin
            checks++; errors++;
            $display("FAIL wr_ack_timeout: got %0d acks, expected %0d", k, ML);
        end
        wait_cycle(t + ML + 1);
        check("turn_busy", 32'(busy), 32'd1);
        check("turn_cs", 32'(ram_cs), 32'd0);
        check("turn_we", 32'(ram_we), 32'd0);
        check("turn_oe", 32'(ram_oe), 32'd0);
        check("turn_bus", 32'(bus_busy()), 32'd0);
        wait_cycle(t + ML + 2);
        check("wr_idle_busy", 32'(busy), 32'd0);
        if (chain) begin
            push_read(cbase, t + ML + 2);
            @(negedge clk);
            rd_req = 1'b0;
        end
    endtask

    initial begin
        int t;
        rst = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        rd_base = '0;
        wr_base = '0;
        wr_data = '0;
        for (int k = 0; k < 1024; k++) begin
            mem[k]     = (k < 5) ? DW'(k) : '0;
            ref_mem[k] = (k < 5) ? DW'(k) : '0;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_done", 32'(rd_done), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_bus", 32'(bus_busy()), 32'd0);
        rst = 1'b0;

        // tie right after reset, both held: R, W, R, W
        @(negedge clk);
        t = cyc;
        for (int i = 0; i < ML; i++) wbuf[i] = 8'h5A;
        rd_base = 10'h100;
        wr_base = 10'h200;
        wr_data = 8'h5A;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        push_read(10'h100, t);
        push_write(10'h200, t + 8, ML);
        push_read(10'h100, t + 15);
        push_write(10'h200, t + 23, ML);
        wait_cycle(t + 24);
        rd_req = 1'b0;
        wr_req = 1'b0;
        wait_cycle(t + 31);
        check("alt_idle", 32'(busy), 32'd0);

        // single-cycle read pulse of the preloaded bytes
        run_read(10'h000);

        // wrapping write, then a read queued during it
        wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3; wbuf[4] = 8'hA4;
        run_write(10'h3FE, 1'b1, 10'h3FE);
        wait_idle();

        // reset in the third write cycle
        wbuf[0] = 8'hB0; wbuf[1] = 8'hB1; wbuf[2] = 8'hB2; wbuf[3] = 8'hB3; wbuf[4] = 8'hB4;
        wait_idle();
        t = cyc;
        wr_base = 10'h040;
        wr_data = wbuf[0];
        wr_req  = 1'b1;
        push_write(10'h040, t, 2);
        @(posedge clk); #1 wr_req = 1'b0;
        @(posedge clk); #1 wr_data = wbuf[1];
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("mid_rst_wr_ack", 32'(wr_ack), 32'd0);
        check("mid_rst_wr_done", 32'(wr_done), 32'd0);
        check("mid_rst_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bus", 32'(bus_busy()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_read(10'h040);

        repeat (3) @(negedge clk);
        check("rd_q_empty", 32'(rd_exp_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_exp_q.size()), 32'd0);
        check("grant_q_empty", 32'(g_cyc_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        checks++;
        $display("FAIL timeout: simulation reached time limit, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
